// File: rtl/axi_read_address_channel_if.sv
// rtl/axi_read_address_channel_if.sv - AXI read-address channel signal bundle
// Master drives the AR payload and ARVALID; slave answers with ARREADY.
interface axi_read_address_channel_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [3:0]            ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY
  );
endinterface

// File: rtl/axi_read_address_channel.sv
// rtl/axi_read_address_channel.sv - AXI AR master splitting reads into 4 KB-safe INCR bursts
// One burst is in flight at a time; each is handed to the read-data channel via go.
module axi_read_address_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  total_beats,
  input  logic [3:0]            cmd_id,
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  cmd_error,
  axi_read_address_channel_if.master ar,
  output logic                  go,
  input  logic                  chan_done,
  input  logic                  chan_error
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int BW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ADDR, S_DATA, S_RELEASE, S_FINISH, S_REJECT, S_FAULT
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [BW-1:0]         burst_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [3:0]            ar_id_q;
  logic [12:0]           to4k_bytes;
  logic [BW-1:0]         to4k;
  logic [BW-1:0]         burst;
  logic                  cmd_bad;

  // Burst length is the smallest of beats left, the burst cap and beats to the next 4 KB page.
  always_comb begin
    to4k_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
    to4k       = BW'(to4k_bytes >> SIZE);
    burst      = BW'(remaining_q);
    if (BW'(MAX_BURST) < burst) burst = BW'(MAX_BURST);
    if (to4k < burst)           burst = to4k;
  end

  assign cmd_bad = (total_beats == '0) || ((start_addr & ALIGN_MASK) != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = cmd_bad ? S_REJECT : S_CALC;
      S_CALC:    state_nx = S_ADDR;
      S_ADDR:    if (ar.ARREADY) state_nx = S_DATA;
      S_DATA: begin
        if (chan_error)     state_nx = S_FAULT;
        else if (chan_done) state_nx = S_RELEASE;
      end
      S_RELEASE: state_nx = (remaining_q != '0) ? S_CALC : S_FINISH;
      S_FINISH,
      S_REJECT,
      S_FAULT:   state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_id_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr_q      <= start_addr;
          remaining_q <= total_beats;
          ar_id_q     <= cmd_id;
        end
        S_CALC: begin
          burst_q   <= burst;
          ar_addr_q <= addr_q;
          ar_len_q  <= 8'(burst - 1'b1);
        end
        // Advance only on the handshake so the AR payload stays stable while stalled.
        S_ADDR: if (ar.ARREADY) begin
          addr_q      <= addr_q + (ADDR_WIDTH'(burst_q) << SIZE);
          remaining_q <= remaining_q - LEN_WIDTH'(burst_q);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign cmd_done   = (state == S_FINISH);
  assign cmd_error  = (state == S_REJECT) || (state == S_FAULT);
  assign go         = (state == S_DATA);
  assign ar.ARVALID = (state == S_ADDR);
  assign ar.ARADDR  = ar_addr_q;
  assign ar.ARLEN   = ar_len_q;
  assign ar.ARID    = ar_id_q;
  assign ar.ARSIZE  = 3'(SIZE);
  assign ar.ARBURST = 2'b01;
endmodule
